// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
// Action enum, counter-width function, zero-register index.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    HAZ_NONE,
    HAZ_STALL,
    HAZ_FLUSH
  } haz_action_e;

  localparam int ZERO_REG = 0;

  // Bits needed to hold 0..max_val, never less than 1.
  function automatic int cnt_width(input int max_val);
    if (max_val <= 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: countdown until a register is forwardable.
// Ports: clk, rst_n, load_en, load_val in; busy out (count nonzero).
module hazard_sb_entry #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A new writer overrides the running countdown (newest wins).
  always_comb begin
    cnt_d = cnt_q;
    if (load_en) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and stall/flush control between ID and ID/EX.
// In: issue/source info from ID, branch_taken from EX.
// Out: pc/IF-ID enables, bubble select, IF/ID flush, stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W         = 4,
  parameter int LOAD_LATENCY       = 1,
  parameter int ALU_LATENCY        = 0,
  parameter int BRANCH_PENALTY     = 1,
  parameter bit ZERO_REG_HARDWIRED = 1'b1,
  parameter int STALL_CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic                   issue_writes_rd,
  input  logic                   issue_is_load,
  input  logic [REG_ADDR_W-1:0]  issue_rd,
  input  logic [REG_ADDR_W-1:0]  id_rs_a,
  input  logic [REG_ADDR_W-1:0]  id_rs_b,
  input  logic                   id_uses_a,
  input  logic                   id_uses_b,
  input  logic                   branch_taken,
  output logic                   pc_enable,
  output logic                   if_id_enable,
  output logic                   bubble_sel,
  output logic                   flush_if_id,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int NREG = 2 ** REG_ADDR_W;
  localparam int LAT_MAX =
    (LOAD_LATENCY > ALU_LATENCY) ? LOAD_LATENCY : ALU_LATENCY;
  localparam int CNT_W = cnt_width(LAT_MAX);
  localparam int FL_W  = cnt_width(BRANCH_PENALTY - 1);
  localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);

  logic [NREG-1:0]        busy;
  logic [NREG-1:0]        load_en;
  logic [CNT_W-1:0]       load_val;
  logic                   haz_a;
  logic                   haz_b;
  logic                   stall;
  logic                   flush_active;
  logic                   accept;
  logic                   rd_zero;
  haz_action_e            act;

  logic [FL_W-1:0]        flush_cnt_q;
  logic [FL_W-1:0]        flush_cnt_d;
  logic [STALL_CNT_W-1:0] stall_count_q;
  logic [STALL_CNT_W-1:0] stall_count_d;

  for (genvar r = 0; r < NREG; r++) begin : g_sb
    hazard_sb_entry #(
      .CNT_W(CNT_W)
    ) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_en (load_en[r]),
      .load_val(load_val),
      .busy    (busy[r])
    );
  end

  // Outputs must read idle while reset is held, even with a branch.
  always_comb begin
    haz_a = id_uses_a && busy[id_rs_a]
         && !(ZERO_REG_HARDWIRED && id_rs_a == ZR);
    haz_b = id_uses_b && busy[id_rs_b]
         && !(ZERO_REG_HARDWIRED && id_rs_b == ZR);
    stall = rst_n && issue_valid && (haz_a || haz_b);
    flush_active = rst_n
                && (branch_taken || flush_cnt_q != '0);
    accept = issue_valid && issue_writes_rd && !stall
          && !flush_active && !branch_taken;
    rd_zero = ZERO_REG_HARDWIRED && issue_rd == ZR;
  end

  always_comb begin
    load_en = '0;
    load_val = issue_is_load ? CNT_W'(LOAD_LATENCY)
                             : CNT_W'(ALU_LATENCY);
    if (accept && !rd_zero) load_en[issue_rd] = 1'b1;
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (branch_taken) begin
      flush_cnt_d = FL_W'(BRANCH_PENALTY - 1);
    end else if (flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - FL_W'(1);
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !flush_active && stall_count_q != '1) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_comb begin
    act = HAZ_NONE;
    unique case (1'b1)
      flush_active:          act = HAZ_FLUSH;
      stall && !flush_active: act = HAZ_STALL;
      default:               act = HAZ_NONE;
    endcase
  end

  always_comb begin
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    bubble_sel   = 1'b0;
    flush_if_id  = 1'b0;
    unique case (act)
      HAZ_FLUSH: begin
        bubble_sel  = 1'b1;
        flush_if_id = 1'b1;
      end
      HAZ_STALL: begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        bubble_sel   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q   <= '0;
      stall_count_q <= '0;
    end else begin
      flush_cnt_q   <= flush_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
